// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths and source IDs.
package wb_arbiter_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback buffer: DEPTH-entry FIFO with registered occupancy.
// ready is derived from the occupancy register only, so it never depends on push.
module wb_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign ready   = (count < CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results and issues one register-file
// write per cycle. Define WB_RR_EN for round-robin on contention (default: mem wins).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] wrt_data
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] alu_head;
    logic [ENTRY_W-1:0] mem_head;
    logic [ENTRY_W-1:0] sel_head;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;
    logic               alu_empty;
    logic               mem_empty;
    logic               alu_pop;
    logic               mem_pop;
    logic               any_pending;
    logic               contended;
    src_e               grant;

    wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_valid),
        .push_data ({alu_rd, alu_data}),
        .pop       (alu_pop),
        .head      (alu_head),
        .empty     (alu_empty),
        .ready     (alu_ready)
    );

    wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_valid),
        .push_data ({mem_rd, mem_data}),
        .pop       (mem_pop),
        .head      (mem_head),
        .empty     (mem_empty),
        .ready     (mem_ready)
    );

    assign any_pending = !alu_empty || !mem_empty;
    assign contended   = !alu_empty && !mem_empty;

`ifdef WB_RR_EN
    src_e last_grant;

    // Starts at ALU so the first contended grant goes to mem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            last_grant <= SRC_ALU;
        else if (contended) last_grant <= grant;
    end
`endif

    always_comb begin
        grant = SRC_MEM;
        if (contended) begin
`ifdef WB_RR_EN
            grant = (last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
`else
            grant = SRC_MEM;
`endif
        end else if (!alu_empty) begin
            grant = SRC_ALU;
        end
    end

    assign alu_pop  = any_pending && (grant == SRC_ALU);
    assign mem_pop  = any_pending && (grant == SRC_MEM);
    assign sel_head = (grant == SRC_ALU) ? alu_head : mem_head;
    assign sel_rd   = sel_head[ENTRY_W-1:DATA_W];
    assign sel_data = sel_head[DATA_W-1:0];

    // Entries targeting register 0 are drained silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite <= 1'b0;
            rd       <= '0;
            wrt_data <= '0;
        end else if (any_pending) begin
            if (sel_rd != '0) begin
                RegWrite <= 1'b1;
                rd       <= sel_rd;
                wrt_data <= sel_data;
            end else begin
                RegWrite <= 1'b0;
                rd       <= '0;
                wrt_data <= '0;
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; expectations follow WB_RR_EN when it is defined.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [5:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [5:0]  mem_rd = '0;
    logic [63:0] mem_data = '0;
    logic        mem_ready;
    logic        RegWrite;
    logic [5:0]  rd;
    logic [63:0] wrt_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] regs [64];

    wb_arbiter #(.DATA_W(64), .ADDR_W(6), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .wrt_data  (wrt_data)
    );

    always #5 clk = ~clk;

    // Register file written unconditionally on RegWrite, so a write to reg 0 would show.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= '0;
        end else if (RegWrite) begin
            regs[rd] <= wrt_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        n_cmp++;
        if (rd !== 6'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", rd); end
        n_cmp++;
        if (wrt_data !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", wrt_data); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mem_ready: got %b want 1", mem_ready); end
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_idle_regwrite: got %b want 0", RegWrite); end
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 6'd5;
        alu_data  = 64'hAAAABBBBCCCCDDDD;
        tick();
        alu_valid = 1'b0;
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", RegWrite); end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL single_regwrite: got %b want 1", RegWrite); end
        n_cmp++;
        if (rd !== 6'd5) begin n_bad++; $display("FAIL single_rd: got %0d want 5", rd); end
        n_cmp++;
        if (wrt_data !== 64'hAAAABBBBCCCCDDDD) begin n_bad++; $display("FAIL single_data: got %h want aaaabbbbccccdddd", wrt_data); end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL single_after: got %b want 0", RegWrite); end
        n_cmp++;
        if (rd !== 6'd5) begin n_bad++; $display("FAIL single_rd_hold: got %0d want 5", rd); end
        n_cmp++;
        if (regs[5] !== 64'hAAAABBBBCCCCDDDD) begin n_bad++; $display("FAIL single_regfile: got %h want aaaabbbbccccdddd", regs[5]); end
    endtask

    task automatic test_contention();
        do_reset();
        alu_valid = 1'b1; alu_rd = 6'd3; alu_data = 64'd1;
        mem_valid = 1'b1; mem_rd = 6'd4; mem_data = 64'd2;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (RegWrite !== 1'b1 || rd !== 6'd4 || wrt_data !== 64'd2) begin
            n_bad++; $display("FAIL contend_first: got rw=%b rd=%0d data=%0d want rw=1 rd=4 data=2", RegWrite, rd, wrt_data);
        end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b1 || rd !== 6'd3 || wrt_data !== 64'd1) begin
            n_bad++; $display("FAIL contend_second: got rw=%b rd=%0d data=%0d want rw=1 rd=3 data=1", RegWrite, rd, wrt_data);
        end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL contend_idle: got %b want 0", RegWrite); end
        n_cmp++;
        if (regs[3] !== 64'd1 || regs[4] !== 64'd2) begin
            n_bad++; $display("FAIL contend_regfile: got r3=%0d r4=%0d want r3=1 r4=2", regs[3], regs[4]);
        end
    endtask

    task automatic test_zero_rd();
        do_reset();
        alu_valid = 1'b1; alu_rd = 6'd7; alu_data = 64'h77;
        tick();
        alu_rd = 6'd0; alu_data = 64'hFFFFFFFFFFFFFFFF;
        tick();
        alu_valid = 1'b0;
        n_cmp++;
        if (RegWrite !== 1'b1 || rd !== 6'd7) begin n_bad++; $display("FAIL zero_prior: got rw=%b rd=%0d want rw=1 rd=7", RegWrite, rd); end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL zero_regwrite: got %b want 0", RegWrite); end
        n_cmp++;
        if (rd !== 6'd0 || wrt_data !== 64'd0) begin n_bad++; $display("FAIL zero_outputs: got rd=%0d data=%h want rd=0 data=0", rd, wrt_data); end
        tick();
        n_cmp++;
        if (regs[0] !== 64'd0) begin n_bad++; $display("FAIL zero_regfile: got %h want 0", regs[0]); end
        n_cmp++;
        if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL zero_drained: got %b want 1", alu_ready); end
    endtask

    task automatic test_sustained_mem();
        int k;
        int got;
        bit acc;
        int exp_rw [8];
        int exp_rd [8];
        exp_rw[0] = 0; exp_rd[0] = 0;
        for (int e = 1; e < 8; e++) begin exp_rw[e] = 1; exp_rd[e] = 10; end
`ifdef WB_RR_EN
        exp_rd[2] = 20; exp_rd[4] = 21; exp_rd[6] = 22;
`endif
        do_reset();
        k = 0;
        mem_valid = 1'b1; mem_rd = 6'd10; mem_data = 64'h10;
        alu_valid = 1'b1; alu_rd = 6'd20; alu_data = 64'h20;
        for (int e = 0; e < 8; e++) begin
            acc = alu_valid && alu_ready;
            tick();
            if (acc) begin
                k++;
                if (k == 3) alu_valid = 1'b0;
                else alu_rd = 6'(20 + k);
            end
            n_cmp++;
            if (RegWrite !== exp_rw[e][0] || (exp_rw[e] == 1 && rd !== 6'(exp_rd[e]))) begin
                n_bad++; $display("FAIL sustain_edge%0d: got rw=%b rd=%0d want rw=%0d rd=%0d", e + 1, RegWrite, rd, exp_rw[e], exp_rd[e]);
            end
        end
        mem_valid = 1'b0;
`ifdef WB_RR_EN
        n_cmp++;
        if (alu_ready !== 1'b1 || k != 3) begin n_bad++; $display("FAIL sustain_rr_drain: got ready=%b accepted=%0d want ready=1 accepted=3", alu_ready, k); end
`else
        n_cmp++;
        if (alu_ready !== 1'b0 || k != 2) begin n_bad++; $display("FAIL sustain_alu_full: got ready=%b accepted=%0d want ready=0 accepted=2", alu_ready, k); end
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            acc = alu_valid && alu_ready;
            tick();
            if (acc) begin
                k++;
                if (k == 3) alu_valid = 1'b0;
                else alu_rd = 6'(20 + k);
            end
            if (RegWrite === 1'b1 && rd >= 6'd20) begin
                n_cmp++;
                if (rd !== 6'(20 + got)) begin n_bad++; $display("FAIL sustain_alu_order: got rd=%0d want %0d", rd, 20 + got); end
                got++;
            end
        end
        n_cmp++;
        if (got != 3) begin n_bad++; $display("FAIL sustain_alu_timeout: got %0d alu writes want 3", got); end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_during();
        int writes;
        do_reset();
        alu_valid = 1'b1; alu_rd = 6'd9;  alu_data = 64'h99;
        mem_valid = 1'b1; mem_rd = 6'd11; mem_data = 64'hBB;
        repeat (3) tick();
        n_cmp++;
        if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL rstmid_active: got %b want 1", RegWrite); end
        rst = 1'b1;
        idle_inputs();
        #1;
        n_cmp++;
        if (RegWrite !== 1'b0 || rd !== 6'd0 || wrt_data !== 64'd0) begin
            n_bad++; $display("FAIL rstmid_async: got rw=%b rd=%0d data=%h want all 0", RegWrite, rd, wrt_data);
        end
        tick();
        tick();
        rst = 1'b0;
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (RegWrite !== 1'b0) writes++;
        end
        n_cmp++;
        if (writes != 0) begin n_bad++; $display("FAIL rstmid_no_write: got %0d writes want 0", writes); end
        n_cmp++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_ready: got alu=%b mem=%b want 1 1", alu_ready, mem_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_zero_rd();
        test_sustained_mem();
        test_reset_during();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
